mem_access: RTL

//  MEM-stage memory access unit, directly upstream of the MEM/WB register. Takes

---
 rtl/mem_access.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM-stage memory access unit: req/ack bus handshake with pipeline freeze,
// bubble insertion into MEM/WB and a sticky bus timeout flag.
module mem_access #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_mem,
  input  logic          memread_mem,
  input  logic          memwrite_mem,
  input  logic [AW-1:0] adr_mem,
  input  logic [DW-1:0] wdat_mem,
  input  logic          flush_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdat,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdat,
  output logic [DW-1:0] main_mem_dat,
  output logic          stall_mem,
  output logic          bubble_mem,
  output logic          mem_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_abort;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdat;
  logic [DW-1:0] r_dat;
  logic          r_err;

  logic w_access;
  logic w_abort;
  logic w_stall;

  assign w_access = valid_mem & (memread_mem | memwrite_mem) & ~flush_mem;
  // A flush arriving in the completing cycle still cancels the DONE slot.
  assign w_abort  = r_abort | flush_mem;

  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      S_IDLE:  w_stall = w_access;
      S_WAIT:  w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_dat   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_adr   <= adr_mem;
            r_wdat  <= wdat_mem;
            r_we    <= memwrite_mem;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_req   <= 1'b0;
            if (!r_we) r_dat <= mem_rdat;
            r_state <= w_abort ? S_IDLE : S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_req   <= 1'b0;
            r_dat   <= '0;
            r_err   <= 1'b1;
            r_state <= w_abort ? S_IDLE : S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_abort <= w_abort;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req      = r_req;
  assign mem_we       = r_we;
  assign mem_adr      = r_adr;
  assign mem_wdat     = r_wdat;
  assign main_mem_dat = r_dat;
  assign mem_err      = r_err;
  assign stall_mem    = w_stall;
  assign bubble_mem   = w_stall;

endmodule
